// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encodings, fault cause codes, the prefetch entry layout and the PC
// legality helper. Other blocks, such as a hazard/control unit, can import
// this package to decode fault_cause.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_FULL  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10
    } fault_cause_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    // If a PC is both misaligned and out of range, it is reported as
    // misaligned.
    function automatic fault_cause_e pc_check(input logic [31:0] pc,
                                              input logic [31:0] last_pc);
        if (pc[1:0] != 2'b00) begin
            return FC_MISALIGN;
        end else if (pc > last_pc) begin
            return FC_RANGE;
        end else begin
            return FC_NONE;
        end
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction memory read
// port, the redirect source and decode. The controller uses master; the
// environment uses slave.
interface imem_fetch_ctrl_if;
    logic [31:0] imem_adrs;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    modport master (
        output imem_adrs,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        output fault,
        output fault_cause,
        output fault_pc
    );

    modport slave (
        input  imem_adrs,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        input  fault,
        input  fault_cause,
        input  fault_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl_inst_fifo.sv
// Two-entry prefetch buffer of {pc, inst}. Entry 0 is always the head.
// A flush empties the buffer but leaves the storage untouched, so the head
// outputs keep showing the last head while the buffer is empty.
module inst_fifo
    import imem_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enq_i,
    input  logic        deq_i,
    input  logic        flush_i,
    input  logic [31:0] wr_pc_i,
    input  logic [31:0] wr_inst_i,
    output logic [1:0]  count_o,
    output logic [31:0] head_pc_o,
    output logic [31:0] head_inst_o
);

    fifo_entry_t e0_q;
    fifo_entry_t e1_q;
    fifo_entry_t wr_entry;
    logic [1:0]  count_q;

    assign wr_entry    = '{pc: wr_pc_i, inst: wr_inst_i};
    assign count_o     = count_q;
    assign head_pc_o   = e0_q.pc;
    assign head_inst_o = e0_q.inst;

    // Storage and occupancy. The caller never enqueues into a full buffer
    // without a dequeue, and never dequeues an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            unique case ({enq_i, deq_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_q <= wr_entry;
                    end else begin
                        e1_q <= wr_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= wr_entry;
                    end else begin
                        e0_q <= wr_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller. It owns the PC, fetches one word per cycle
// into a 2-entry prefetch buffer, flushes the buffer on redirects and stops
// with a fault report on a misaligned or out-of-range PC.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | fetching: the PC is checked and enqueued whenever there is room
// ST_FULL  | buffer full with no dequeue: the PC is held
// ST_FAULT | illegal PC seen: fetch stopped, buffer drains, redirect exits
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int          MEM_BYTES = 400,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_fetch_ctrl_if.master bus
);

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         fault_q;
    fault_cause_e fault_cause_q;
    logic [31:0]  fault_pc_q;

    logic [1:0]   count;
    logic [31:0]  head_pc;
    logic [31:0]  head_inst;
    logic         deq;
    logic         fetch_slot;
    logic         enq;
    fault_cause_e pc_cause;
    logic [1:0]   count_d;

    assign bus.imem_adrs   = pc_q;
    assign bus.inst_valid  = (count != 2'd0);
    assign bus.inst        = head_inst;
    assign bus.inst_pc     = head_pc;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = fault_cause_q;
    assign bus.fault_pc    = fault_pc_q;

    // A fetch slot exists when the buffer has room this cycle and no
    // redirect is pending. The PC check happens only in a fetch slot, so a
    // wrapped or out-of-range PC faults before it can be enqueued.
    always_comb begin
        deq        = (count != 2'd0) && bus.inst_ready;
        pc_cause   = pc_check(pc_q, LAST_PC);
        fetch_slot = (state_q != ST_FAULT) && !bus.redirect_valid &&
                     ((count != 2'd2) || deq);
        enq        = fetch_slot && (pc_cause == FC_NONE);
        count_d    = count + 2'(enq) - 2'(deq);
    end

    // PC, fault registers and fetch state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            fault_q       <= 1'b0;
            fault_cause_q <= FC_NONE;
            fault_pc_q    <= '0;
        end else if (bus.redirect_valid) begin
            state_q       <= ST_FETCH;
            pc_q          <= bus.redirect_pc;
            fault_q       <= 1'b0;
            fault_cause_q <= FC_NONE;
            fault_pc_q    <= '0;
        end else if (fetch_slot && (pc_cause != FC_NONE)) begin
            state_q       <= ST_FAULT;
            fault_q       <= 1'b1;
            fault_cause_q <= pc_cause;
            fault_pc_q    <= pc_q;
        end else if (state_q != ST_FAULT) begin
            if (enq) begin
                pc_q <= pc_q + 32'd4;
            end
            state_q <= ((count_d == 2'd2) && !deq) ? ST_FULL : ST_FETCH;
        end
    end

    inst_fifo u_inst_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_i       (enq),
        .deq_i       (deq),
        .flush_i     (bus.redirect_valid),
        .wr_pc_i     (pc_q),
        .wr_inst_i   (bus.imem_data),
        .count_o     (count),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl. Inputs are driven at the falling
// edge, and outputs are sampled 1 ns later, so each check sees the values
// for the cycle that ends at the next rising edge.
module tb_imem_fetch_ctrl;

    localparam int MEM_BYTES = 400;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(32'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: readable words exist only below MEM_BYTES.
    always_comb begin
        if (bus.imem_adrs < 32'(MEM_BYTES)) begin
            bus.imem_data = word_at({bus.imem_adrs[31:2], 2'b00});
        end else begin
            bus.imem_data = 32'hBAD0_BAD0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        check({tag, ".valid"}, 32'(bus.inst_valid), 32'd1);
        check({tag, ".inst_pc"}, bus.inst_pc, exp_pc);
        check({tag, ".inst"}, bus.inst, word_at(exp_pc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] e_adrs;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [1:0]  e_cause;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic [31:0] e_adrs, input logic e_valid,
                                input logic [31:0] e_pc, input logic e_fault,
                                input logic [1:0] e_cause, input logic [31:0] e_fpc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_adrs = e_adrs; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_fault = e_fault; v.e_cause = e_cause; v.e_fpc = e_fpc;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'd0, 1'b0);

        // Cycle-by-cycle run from reset: streaming, stall, redirect flush,
        // misaligned-redirect fault and recovery.
        //              rv    rpc       rdy  adrs      val  pc        flt  cause  fpc
        vecs[0]  = mk(1'b0, 32'h0,    1'b1, 32'h00,  1'b0, 32'h00,  1'b0, 2'b00, 32'h0);
        vecs[1]  = mk(1'b0, 32'h0,    1'b1, 32'h04,  1'b1, 32'h00,  1'b0, 2'b00, 32'h0);
        vecs[2]  = mk(1'b0, 32'h0,    1'b1, 32'h08,  1'b1, 32'h04,  1'b0, 2'b00, 32'h0);
        vecs[3]  = mk(1'b0, 32'h0,    1'b1, 32'h0C,  1'b1, 32'h08,  1'b0, 2'b00, 32'h0);
        vecs[4]  = mk(1'b0, 32'h0,    1'b1, 32'h10,  1'b1, 32'h0C,  1'b0, 2'b00, 32'h0);
        vecs[5]  = mk(1'b0, 32'h0,    1'b0, 32'h14,  1'b1, 32'h10,  1'b0, 2'b00, 32'h0);
        vecs[6]  = mk(1'b0, 32'h0,    1'b0, 32'h18,  1'b1, 32'h10,  1'b0, 2'b00, 32'h0);
        vecs[7]  = mk(1'b0, 32'h0,    1'b1, 32'h18,  1'b1, 32'h10,  1'b0, 2'b00, 32'h0);
        vecs[8]  = mk(1'b0, 32'h0,    1'b1, 32'h1C,  1'b1, 32'h14,  1'b0, 2'b00, 32'h0);
        vecs[9]  = mk(1'b0, 32'h0,    1'b1, 32'h20,  1'b1, 32'h18,  1'b0, 2'b00, 32'h0);
        vecs[10] = mk(1'b1, 32'h40,   1'b1, 32'h24,  1'b1, 32'h1C,  1'b0, 2'b00, 32'h0);
        vecs[11] = mk(1'b0, 32'h0,    1'b1, 32'h40,  1'b0, 32'h00,  1'b0, 2'b00, 32'h0);
        vecs[12] = mk(1'b0, 32'h0,    1'b1, 32'h44,  1'b1, 32'h40,  1'b0, 2'b00, 32'h0);
        vecs[13] = mk(1'b1, 32'h42,   1'b1, 32'h48,  1'b1, 32'h44,  1'b0, 2'b00, 32'h0);
        vecs[14] = mk(1'b0, 32'h0,    1'b1, 32'h42,  1'b0, 32'h00,  1'b0, 2'b00, 32'h0);
        vecs[15] = mk(1'b0, 32'h0,    1'b1, 32'h42,  1'b0, 32'h00,  1'b1, 2'b01, 32'h42);
        vecs[16] = mk(1'b1, 32'h10,   1'b1, 32'h42,  1'b0, 32'h00,  1'b1, 2'b01, 32'h42);
        vecs[17] = mk(1'b0, 32'h0,    1'b1, 32'h10,  1'b0, 32'h00,  1'b0, 2'b00, 32'h0);
        vecs[18] = mk(1'b0, 32'h0,    1'b1, 32'h14,  1'b1, 32'h10,  1'b0, 2'b00, 32'h0);
        vecs[19] = mk(1'b0, 32'h0,    1'b0, 32'h18,  1'b1, 32'h14,  1'b0, 2'b00, 32'h0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            #1;
            check($sformatf("v%0d.adrs", i), bus.imem_adrs, vecs[i].e_adrs);
            check($sformatf("v%0d.valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d.inst_pc", i), bus.inst_pc, vecs[i].e_pc);
                check($sformatf("v%0d.inst", i), bus.inst, word_at(vecs[i].e_pc));
            end
            check($sformatf("v%0d.fault", i), 32'(bus.fault), 32'(vecs[i].e_fault));
            check($sformatf("v%0d.cause", i), 32'(bus.fault_cause), 32'(vecs[i].e_cause));
            if (vecs[i].e_fault) begin
                check($sformatf("v%0d.fault_pc", i), bus.fault_pc, vecs[i].e_fpc);
            end
        end

        // Stall straight after reset: the buffer fills with PCs 0 and 4, and
        // the PC holds at 8. Those words then drain back-to-back.
        do_reset();
        drive(1'b0, 32'd0, 1'b0);
        #1;
        check("rst.valid", 32'(bus.inst_valid), 32'd0);
        check("rst.inst", bus.inst, 32'd0);
        check("rst.inst_pc", bus.inst_pc, 32'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        check("stall.adrs", bus.imem_adrs, 32'd8);
        check_head("stall.head", 32'd0);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_head($sformatf("drain%0d", i), 32'(4 * i));
            @(negedge clk);
        end
        #1;
        check_head("drain3", 32'd12);

        // Sequential run off the end of memory: 392 and 396 are delivered,
        // and 400 faults with no entry enqueued.
        drive(1'b1, 32'd392, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1);
        #1;
        check("end.adrs0", bus.imem_adrs, 32'd392);
        check("end.valid0", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        #1;
        check_head("end.h392", 32'd392);
        @(negedge clk);
        #1;
        check_head("end.h396", 32'd396);
        check("end.nofault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        #1;
        check("end.fault", 32'(bus.fault), 32'd1);
        check("end.cause", 32'(bus.fault_cause), 32'd2);
        check("end.fault_pc", bus.fault_pc, 32'd400);
        check("end.valid_off", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        #1;
        check("end.still_empty", 32'(bus.inst_valid), 32'd0);
        check("end.pc_held", bus.imem_adrs, 32'd400);

        // Misaligned and out of range at the same time: misaligned wins.
        drive(1'b1, 32'h1F2, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1);
        #1;
        check("both.cleared", 32'(bus.fault), 32'd0);
        @(negedge clk);
        #1;
        check("both.cause", 32'(bus.fault_cause), 32'd1);
        check("both.fault_pc", bus.fault_pc, 32'h1F2);

        // Last word of the 32-bit space: out of range, so the pc+4 wrap can
        // never be reached.
        drive(1'b1, 32'hFFFF_FFFC, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1);
        @(negedge clk);
        #1;
        check("top.cause", 32'(bus.fault_cause), 32'd2);
        check("top.valid", 32'(bus.inst_valid), 32'd0);

        // Reset asserted mid-stream with a full buffer clears all state at
        // once; fetch then restarts at the reset PC.
        drive(1'b1, 32'h80, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        check_head("mid.full", 32'h80);
        check("mid.adrs", bus.imem_adrs, 32'h88);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.rst_valid", 32'(bus.inst_valid), 32'd0);
        check("mid.rst_adrs", bus.imem_adrs, 32'd0);
        check("mid.rst_inst", bus.inst, 32'd0);
        check("mid.rst_inst_pc", bus.inst_pc, 32'd0);
        check("mid.rst_fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        check("mid.restart_adrs", bus.imem_adrs, 32'd0);
        @(negedge clk);
        #1;
        check_head("mid.restart", 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller for the instruction memory. It owns the program counter and drives the memory read address each cycle. Each fetched word is captured, with its PC, into a 2-entry prefetch buffer that feeds decode through a valid/ready handshake. It also handles branch/jump redirects with a buffer flush, and stops fetching with a fault report on misaligned or out-of-range PCs.

## Interface
Parameters:
- MEM_BYTES, 400, instruction memory size in bytes; valid PCs are 0 .. MEM_BYTES-4.
- RESET_PC, 32'd0, PC loaded at reset; must be word-aligned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_adrs  output  32  byte address to the instruction memory read port; equals the PC register (combinational from the flop).
- imem_data  input  32  big-endian word returned combinationally by the memory for imem_adrs.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target PC; sampled when redirect_valid=1.
- inst_valid  output  1  buffer head holds an instruction.
- inst  output  32  head instruction word.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- fault  output  1  fetch stopped on an illegal PC.
- fault_cause  output  2  01 = misaligned (pc[1:0]≠0), 10 = out of range (pc > MEM_BYTES-4); misaligned wins if both apply.
- fault_pc  output  32  offending PC.

## Operation
- States: FETCH, FULL, FAULT.
- FETCH: if the PC is legal, enqueue {imem_data, pc} and set pc ← pc+4 at the clock edge. If the PC is illegal, go to FAULT: fault=1, fault_cause and fault_pc latched, no enqueue.
- FULL: entered when count reaches 2 and no dequeue occurs. The PC is held and no enqueue occurs. Leave to FETCH on the cycle a dequeue occurs; that cycle enqueues as well.
- FAULT: no enqueue, PC held, buffer still drains normally. Exit only via redirect or reset.
- Enqueue condition in FETCH: count<2, or count=2 with a dequeue in the same cycle (simultaneous enq/deq keeps count=2).
- Dequeue: inst_valid && inst_ready. inst_valid = (count≠0).
- Redirect (any state): buffer flushed (count←0) and pc←redirect_pc. No enqueue that cycle. A dequeue in the same cycle is counted as consumed, then the flush applies.
  - Next state is FETCH.
  - fault clears on the same edge.
  - If redirect_pc is illegal, the next FETCH cycle re-enters FAULT with the new fault_pc.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32. The range check catches the wrap before any enqueue.
- inst/inst_pc are don't-care in value when inst_valid=0 but must be driven (hold last head or zero).

## Timing
- Reset values: pc=RESET_PC, imem_adrs=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0, fault=0, fault_cause=0, fault_pc=0, state=FETCH.
- Reset asserted mid-operation clears everything immediately (asynchronous), including buffer contents and fault.
- Latency: the word at PC p is visible as inst/inst_pc=p one cycle after imem_adrs=p (the first edge after the fetch cycle).
- Throughput: 1 instruction/cycle with inst_ready held high.
- Redirect penalty: first target instruction is valid 2 cycles after the redirect_valid cycle.
- Fault detection: fault asserts on the edge ending the cycle in which imem_adrs held the illegal PC.
- The memory is read combinationally, so there are no memory wait states.

## Structure
- A shared include (fetch_defs.vh) holds state encodings (FETCH, FULL, FAULT) and fault cause codes (FC_NONE=00, FC_MISALIGN=01, FC_RANGE=10), for use by the hazard/control unit.
- One sub-module: inst_fifo, a 2-entry FIFO of {pc[31:0], inst[31:0]} with enq/deq/flush, count output and head outputs.
- Top level: PC register, legality check, state machine, inst_fifo instance.

## Test plan
- Reset release, memory preloaded with words W0..W3 at 0,4,8,12, inst_ready=1 → inst_pc 0,4,8,12 on consecutive cycles starting 1 cycle after reset, inst=W0..W3, fault=0.
- inst_ready=0 for 5 cycles after reset → count saturates at 2 (PCs 0,4), pc holds at 8. On ready=1, PCs 0,4,8 emerge back-to-back with none dropped or duplicated.
- Redirect to 0x40 while the buffer holds PCs 8,12 and inst_ready=1 → PC 8 consumed that cycle, 12 discarded, next valid inst_pc=0x40 two cycles after the redirect.
- Redirect to 0x42 → fault=1, fault_cause=01, fault_pc=0x42, inst_valid drops to 0. A later redirect to 0x10 clears fault and delivers inst_pc=0x10.
- Sequential run from PC 392 (MEM_BYTES=400) → PCs 392 and 396 delivered, then fault=1, cause=10, fault_pc=400, no PC-400 entry.
- rst_n pulsed low mid-stream with count=2 and fault=0 → outputs return to reset values immediately, and fetch restarts at RESET_PC after release.
